// File: rtl/explode_dispatcher.sv
// Purpose: buffers Keccak states, writes each to scratchpad BRAM, then starts a free explode channel round-robin.
// Latency: accept in cycle t with empty FIFO and a free channel -> o_wr_en at t+2, o_start at t+3; one dispatch per 3 cycles.
// Backpressure: o_ready drops when the FIFO is full; entries wait in the FIFO while every channel is busy.

// Small synchronous FIFO with a registered occupancy count and a read-side peek of the head entry.
module explode_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (rd_vld) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_vld, rd_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
endmodule

module explode_dispatcher #(
    parameter int STATE_W    = 1600,
    parameter int BLOCK_W    = 1024,
    parameter int KEY_W      = 256,
    parameter int NONCE_W    = 7,
    parameter int ADDR_W     = 9,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_valid,
    input  logic [STATE_W-1:0]              i_v_state,
    input  logic [NONCE_W-1:0]              i_v_nonce,
    output logic                            o_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count,
    output logic                            o_wr_en,
    output logic [ADDR_W-1:0]               o_v_addr,
    output logic [STATE_W-1:0]              o_v_state,
    output logic [BLOCK_W-1:0]              o_v_block,
    output logic [KEY_W-1:0]                o_v_key,
    output logic [NONCE_W-1:0]              o_v_nonce,
    output logic [NUM_CH-1:0]               o_start,
    output logic [NUM_CH-1:0]               o_busy,
    input  logic [NUM_CH-1:0]               i_ex_done,
    input  logic [NUM_CH-1:0]               i_AXI_done,
    output logic [NUM_CH-1:0]               o_rstn_explode
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = NONCE_W + STATE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2
    } fsm_t;

    fsm_t state_q, state_d;

    logic             push, pop, dispatch;
    logic [ENT_W-1:0] head;
    logic [CNT_W-1:0] count;

    logic [STATE_W-1:0] out_state_q;
    logic [NONCE_W-1:0] out_nonce_q;
    logic [CH_W-1:0]    sel_q, rr_q, pick, rr_next;
    logic [CH_W:0]      sum, rr_inc;
    logic               pick_vld;

    logic [NUM_CH-1:0] busy_q, ex_flag_q, axi_flag_q, complete, rstn_ex_q;

    assign o_ready      = (count < CNT_W'(FIFO_DEPTH));
    assign push         = i_valid && o_ready;
    assign pop          = (state_q == START);
    assign o_fifo_count = count;

    explode_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_vld (push),
        .wr_dat ({i_v_nonce, i_v_state}),
        .rd_vld (pop),
        .rd_dat (head),
        .count  (count)
    );

    // First free channel at or after the round-robin pointer; lowest offset wins.
    always_comb begin
        pick     = rr_q;
        pick_vld = 1'b0;
        sum      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, rr_q} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
            if (!busy_q[sum[CH_W-1:0]]) begin
                pick     = sum[CH_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Pointer advances past the channel just started, wrapping at NUM_CH.
    always_comb begin
        rr_inc  = {1'b0, sel_q} + 1'b1;
        rr_next = (rr_inc >= (CH_W+1)'(NUM_CH)) ? '0 : rr_inc[CH_W-1:0];
    end

    // Dispatcher state register.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Dispatcher next-state and strobes: one BRAM write cycle, then one start cycle.
    always_comb begin
        state_d = state_q;
        o_wr_en = 1'b0;
        o_start = '0;
        case (state_q)
            IDLE: begin
                if ((count != '0) && pick_vld) state_d = LOAD;
            end
            LOAD: begin
                o_wr_en = 1'b1;
                state_d = START;
            end
            START: begin
                o_start = NUM_CH'(1) << sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dispatch = (state_q == IDLE) && (state_d == LOAD);

    // Output data and channel select are captured only when a dispatch begins and held until the next one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_state_q <= '0;
            out_nonce_q <= '0;
            sel_q       <= '0;
            rr_q        <= '0;
        end else begin
            if (dispatch) begin
                out_state_q <= head[STATE_W-1:0];
                out_nonce_q <= head[ENT_W-1:STATE_W];
                sel_q       <= pick;
            end
            if (state_q == START) rr_q <= rr_next;
        end
    end

    // A channel completes once both done sources have been seen, counting the current-cycle pulses.
    assign complete = busy_q & (ex_flag_q | i_ex_done) & (axi_flag_q | i_AXI_done);

    // Per-channel occupancy, sticky done flags and the one-cycle post-completion channel reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q     <= '0;
            ex_flag_q  <= '0;
            axi_flag_q <= '0;
            rstn_ex_q  <= '0;
        end else begin
            ex_flag_q  <= (ex_flag_q  | (i_ex_done  & busy_q)) & ~complete;
            axi_flag_q <= (axi_flag_q | (i_AXI_done & busy_q)) & ~complete;
            busy_q     <= (busy_q & ~complete) | o_start;
            rstn_ex_q  <= ~complete;
        end
    end

    assign o_busy         = busy_q;
    assign o_rstn_explode = rstn_ex_q;
    assign o_v_state      = out_state_q;
    assign o_v_nonce      = out_nonce_q;
    assign o_v_addr       = ADDR_W'(out_nonce_q);
    assign o_v_block      = out_state_q[BLOCK_W+2*KEY_W-1 -: BLOCK_W];
    assign o_v_key        = out_state_q[KEY_W-1:0];
endmodule

// File: tb/tb_explode_dispatcher.sv
// Directed bench for explode_dispatcher: queue-based reference model checked every cycle plus literal spot checks.
module tb_explode_dispatcher;
    localparam int STATE_W = 1600, BLOCK_W = 1024, KEY_W = 256;
    localparam int NONCE_W = 7, ADDR_W = 9, N = 2, D = 4;

    logic clk = 1'b0;
    logic rstn, i_valid;
    logic [STATE_W-1:0] i_v_state;
    logic [NONCE_W-1:0] i_v_nonce;
    logic o_ready, o_wr_en;
    logic [2:0] o_fifo_count;
    logic [ADDR_W-1:0] o_v_addr;
    logic [STATE_W-1:0] o_v_state;
    logic [BLOCK_W-1:0] o_v_block;
    logic [KEY_W-1:0] o_v_key;
    logic [NONCE_W-1:0] o_v_nonce;
    logic [N-1:0] o_start, o_busy, i_ex_done, i_AXI_done, o_rstn_explode;

    int n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    explode_dispatcher #(
        .STATE_W(STATE_W), .BLOCK_W(BLOCK_W), .KEY_W(KEY_W), .NONCE_W(NONCE_W),
        .ADDR_W(ADDR_W), .NUM_CH(N), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_v_state(i_v_state), .i_v_nonce(i_v_nonce),
        .o_ready(o_ready), .o_fifo_count(o_fifo_count), .o_wr_en(o_wr_en), .o_v_addr(o_v_addr),
        .o_v_state(o_v_state), .o_v_block(o_v_block), .o_v_key(o_v_key), .o_v_nonce(o_v_nonce),
        .o_start(o_start), .o_busy(o_busy), .i_ex_done(i_ex_done), .i_AXI_done(i_AXI_done),
        .o_rstn_explode(o_rstn_explode)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [STATE_W-1:0] act, input logic [STATE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual_lo=%h required_lo=%h (t=%0t)", nm, act[63:0], exp[63:0], $time);
        end
    endtask

    // Lane i of the state for nonce n is {n, i, 48'h0}, so slices are easy to compute by hand.
    function automatic logic [STATE_W-1:0] mk_state(input logic [NONCE_W-1:0] n);
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[i*64 +: 64] = {8'(n), 8'(i), 48'h0};
        return s;
    endfunction

    // Reference model: pending entries in a queue, dispatch as a three-phase job per entry.
    logic [STATE_W-1:0] mq_state[$];
    logic [NONCE_W-1:0] mq_nonce[$];
    logic [N-1:0] m_busy = '0, m_exf = '0, m_axf = '0, m_rstx = '0;
    int m_rr = 0, m_sel = 0, m_phase = 0;
    logic [STATE_W-1:0] m_state = '0;
    logic [NONCE_W-1:0] m_nonce = '0;

    initial begin : model_p
        logic [N-1:0] fin;
        int pick;
        bit take;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                mq_state.delete(); mq_nonce.delete();
                m_busy = '0; m_exf = '0; m_axf = '0; m_rstx = '0;
                m_rr = 0; m_sel = 0; m_phase = 0; m_state = '0; m_nonce = '0;
            end else begin
                take = i_valid && (mq_state.size() < D);
                fin = m_busy & (m_exf | i_ex_done) & (m_axf | i_AXI_done);
                pick = -1;
                if (m_phase == 0 && mq_state.size() > 0)
                    for (int k = N - 1; k >= 0; k--)
                        if (!m_busy[(m_rr + k) % N]) pick = (m_rr + k) % N;
                m_exf = (m_exf | (i_ex_done & m_busy)) & ~fin;
                m_axf = (m_axf | (i_AXI_done & m_busy)) & ~fin;
                m_busy = m_busy & ~fin;
                m_rstx = ~fin;
                if (m_phase == 2) begin
                    m_busy[m_sel] = 1'b1;
                    m_rr = (m_sel + 1) % N;
                    void'(mq_state.pop_front());
                    void'(mq_nonce.pop_front());
                    m_phase = 0;
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (pick >= 0) begin
                    m_sel = pick; m_state = mq_state[0]; m_nonce = mq_nonce[0]; m_phase = 1;
                end
                if (take) begin
                    mq_state.push_back(i_v_state);
                    mq_nonce.push_back(i_v_nonce);
                end
            end
        end
    end

    // Every cycle after reset settles, all outputs are compared with the model.
    initial begin : compare_p
        logic [N-1:0] es;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                es = '0;
                if (m_phase == 2) es[m_sel] = 1'b1;
                chk("m_ready", 64'(o_ready), 64'(mq_state.size() < D));
                chk("m_count", 64'(o_fifo_count), 64'(mq_state.size()));
                chk("m_wr_en", 64'(o_wr_en), 64'(m_phase == 1));
                chk("m_start", 64'(o_start), 64'(es));
                chk("m_busy", 64'(o_busy), 64'(m_busy));
                chk("m_rstn_explode", 64'(o_rstn_explode), 64'(m_rstx));
                chk("m_addr", 64'(o_v_addr), 64'(m_nonce));
                chk("m_nonce", 64'(o_v_nonce), 64'(m_nonce));
                chkw("m_state", o_v_state, m_state);
                chkw("m_block", STATE_W'(o_v_block), STATE_W'(m_state[BLOCK_W+2*KEY_W-1 -: BLOCK_W]));
                chkw("m_key", STATE_W'(o_v_key), STATE_W'(m_state[KEY_W-1:0]));
            end
        end
    end

    task automatic set_push(input logic [NONCE_W-1:0] n);
        i_valid = 1'b1; i_v_nonce = n; i_v_state = mk_state(n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    logic [N-1:0] starts[4];
    int nst;
    logic [N-1:0] saw_start;

    initial begin
        rstn = 1'b0; i_valid = 1'b0; i_v_state = '0; i_v_nonce = '0;
        i_ex_done = '0; i_AXI_done = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", 64'(o_ready), 64'h1);
        chk("rst_count", 64'(o_fifo_count), 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_start", 64'(o_start), 64'h0);
        chk("rst_wr_en", 64'(o_wr_en), 64'h0);
        chk("rst_rstn_explode", 64'(o_rstn_explode), 64'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk("release_rstn_explode", 64'(o_rstn_explode), 64'h3);

        // Single entry, nonce 0x05.
        set_push(7'h05);
        i_valid = 1'b0;
        chk("t1_count", 64'(o_fifo_count), 64'h1);
        chk("t1_wr_early", 64'(o_wr_en), 64'h0);
        @(negedge clk);
        chk("t1_wr_en", 64'(o_wr_en), 64'h1);
        chk("t1_addr", 64'(o_v_addr), 64'h005);
        chk("t1_start_early", 64'(o_start), 64'h0);
        @(negedge clk);
        chk("t1_start", 64'(o_start), 64'h1);
        chkw("t1_key", STATE_W'(o_v_key),
             STATE_W'(256'h0503000000000000_0502000000000000_0501000000000000_0500000000000000));
        chk("t1_block_lo", o_v_block[63:0], 64'h0508000000000000);
        chk("t1_block_hi", o_v_block[1023:960], 64'h0517000000000000);
        @(negedge clk);
        chk("t1_busy", 64'(o_busy), 64'h1);
        chk("t1_count_after", 64'(o_fifo_count), 64'h0);

        // Both done pulses in the same cycle.
        i_ex_done = 2'b01; i_AXI_done = 2'b01;
        @(negedge clk);
        i_ex_done = '0; i_AXI_done = '0;
        chk("same_done_busy", 64'(o_busy), 64'h0);
        chk("same_done_rstx", 64'(o_rstn_explode), 64'h2);
        @(negedge clk);
        chk("same_done_rstx_back", 64'(o_rstn_explode), 64'h3);

        // Round-robin: three entries back to back, no dones.
        do_reset();
        for (int k = 0; k < 3; k++) set_push(NONCE_W'(7'h10 + k));
        i_valid = 1'b0;
        nst = 0;
        for (int k = 0; k < 4; k++) starts[k] = '0;
        repeat (10) begin
            if (o_start != '0 && nst < 4) begin starts[nst] = o_start; nst++; end
            @(negedge clk);
        end
        chk("rr_nstarts", 64'(nst), 64'h2);
        chk("rr_first", 64'(starts[0]), 64'h1);
        chk("rr_second", 64'(starts[1]), 64'h2);
        chk("rr_busy", 64'(o_busy), 64'h3);
        chk("rr_count", 64'(o_fifo_count), 64'h1);
        chk("rr_ready", 64'(o_ready), 64'h1);

        // Split completion on ch0: explode done first, AXI done five cycles later.
        i_ex_done = 2'b01;
        @(negedge clk);
        i_ex_done = '0;
        chk("split_busy_hold", 64'(o_busy), 64'h3);
        repeat (4) @(negedge clk);
        i_AXI_done = 2'b01;
        @(negedge clk);
        i_AXI_done = '0;
        chk("split_busy_fall", 64'(o_busy), 64'h2);
        chk("split_rstx", 64'(o_rstn_explode), 64'h2);
        @(negedge clk);
        chk("split_rstx_back", 64'(o_rstn_explode), 64'h3);
        chk("split_wr_en", 64'(o_wr_en), 64'h1);
        chk("split_addr", 64'(o_v_addr), 64'h012);
        @(negedge clk);
        chk("split_start", 64'(o_start), 64'h1);
        @(negedge clk);
        chk("split_busy_again", 64'(o_busy), 64'h3);
        chk("split_count", 64'(o_fifo_count), 64'h0);

        // Full FIFO while both channels are busy; the fifth push is dropped.
        for (int k = 0; k < 5; k++) set_push(NONCE_W'(7'h20 + k));
        i_valid = 1'b0;
        chk("full_count", 64'(o_fifo_count), 64'h4);
        chk("full_ready", 64'(o_ready), 64'h0);
        i_ex_done = 2'b10; i_AXI_done = 2'b10;
        @(negedge clk);
        i_ex_done = '0; i_AXI_done = '0;
        chk("full_free_busy", 64'(o_busy), 64'h1);
        @(negedge clk);
        chk("full_wr_en", 64'(o_wr_en), 64'h1);
        chk("full_addr", 64'(o_v_addr), 64'h020);
        @(negedge clk);
        chk("full_start", 64'(o_start), 64'h2);
        chk("full_count_pre_pop", 64'(o_fifo_count), 64'h4);
        @(negedge clk);
        chk("full_count_pop", 64'(o_fifo_count), 64'h3);
        chk("full_ready_back", 64'(o_ready), 64'h1);

        // Stray done on an idle channel must not be remembered.
        do_reset();
        i_ex_done = 2'b10;
        @(negedge clk);
        i_ex_done = '0;
        chk("stray_busy", 64'(o_busy), 64'h0);
        chk("stray_rstx", 64'(o_rstn_explode), 64'h3);
        set_push(7'h30);
        set_push(7'h31);
        i_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("stray_both_busy", 64'(o_busy), 64'h3);
        i_AXI_done = 2'b10;
        @(negedge clk);
        i_AXI_done = '0;
        chk("stray_axi_only", 64'(o_busy), 64'h3);
        i_ex_done = 2'b10;
        @(negedge clk);
        i_ex_done = '0;
        chk("stray_complete", 64'(o_busy), 64'h1);
        chk("stray_complete_rstx", 64'(o_rstn_explode), 64'h1);
        @(negedge clk);

        // Reset asserted while a dispatch is in its BRAM-write cycle.
        set_push(7'h33);
        i_valid = 1'b0;
        @(negedge clk);
        chk("midrst_wr_en", 64'(o_wr_en), 64'h1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_start", 64'(o_start), 64'h0);
        chk("midrst_count", 64'(o_fifo_count), 64'h0);
        chk("midrst_busy", 64'(o_busy), 64'h0);
        chk("midrst_rstx", 64'(o_rstn_explode), 64'h0);
        rstn = 1'b1;
        saw_start = '0;
        repeat (5) begin
            @(negedge clk);
            saw_start = saw_start | o_start;
        end
        chk("midrst_no_start", 64'(saw_start), 64'h0);
        chk("midrst_fifo_empty", 64'(o_fifo_count), 64'h0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
